// File: rtl/fir_alu_sequencer.sv
// Cycle scheduler for the shared FP ALU of the FIR: per-sample MUL/ACC/reduce pass
// plus coefficient-port arbitration. Produces addresses, enables and ALU control only.
module fir_alu_sequencer #(
    parameter int TAPS    = 64,
    parameter int ALU_LAT = 5,
    parameter int AW      = $clog2(TAPS)
) (
    input  logic          clk_fast,
    input  logic          rst_n,
    input  logic          sample_valid,
    output logic          sample_ready,
    output logic          din_latch,
    input  logic          cload_req,
    output logic          cload_gnt,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [AW-1:0] cmem_addr,
    output logic          regf_we,
    output logic [AW-1:0] regf_waddr,
    output logic [AW-1:0] regf_raddr,
    output logic          alu_issue,
    output logic [1:0]    alu_op,
    output logic [1:0]    alu_a_sel,
    output logic [1:0]    alu_b_sel,
    output logic          busy,
    output logic          out_valid
);

    localparam int RED_LEN = ALU_LAT * ALU_LAT;
    localparam int CW      = $clog2(TAPS + RED_LEN + 1);

    localparam logic [1:0] OP_NORM = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;
    localparam logic [1:0] A_DIN   = 2'd0;
    localparam logic [1:0] A_DMEM  = 2'd1;
    localparam logic [1:0] A_REGF  = 2'd2;
    localparam logic [1:0] B_CMEM  = 2'd0;
    localparam logic [1:0] B_ZERO  = 2'd1;
    localparam logic [1:0] B_SELF  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_MUL     = 3'd2,
        S_DRAIN   = 3'd3,
        S_ACC     = 3'd4,
        S_COLLECT = 3'd5,
        S_REDUCE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic [AW-1:0] head_r;
    logic [AW-1:0] head_nx_s;
    logic          accept_s;

    logic [CW-1:0] idx_s;
    logic [CW-1:0] k_s;
    logic [CW-1:0] step_s;
    logic [CW-1:0] off_s;
    logic          dmem_we_s;
    logic [AW-1:0] dmem_addr_s;
    logic [AW-1:0] cmem_addr_s;
    logic          regf_we_s;
    logic [AW-1:0] regf_waddr_s;
    logic [AW-1:0] regf_raddr_s;
    logic          alu_issue_s;
    logic [1:0]    alu_op_s;
    logic [1:0]    alu_a_sel_s;
    logic [1:0]    alu_b_sel_s;
    logic          busy_s;
    logic          out_valid_s;

    function automatic state_t next_phase(input state_t st);
        case (st)
            S_LOAD:    next_phase = S_MUL;
            S_MUL:     next_phase = S_DRAIN;
            S_DRAIN:   next_phase = S_ACC;
            S_ACC:     next_phase = S_COLLECT;
            S_COLLECT: next_phase = S_REDUCE;
            S_REDUCE:  next_phase = S_DONE;
            S_DONE:    next_phase = S_IDLE;
            default:   next_phase = S_IDLE;
        endcase
    endfunction

    // Counter load value on phase entry; the counter runs down to zero.
    function automatic logic [CW-1:0] phase_last(input state_t st);
        case (st)
            S_MUL:     phase_last = CW'(TAPS - 2);
            S_DRAIN:   phase_last = CW'(ALU_LAT - 1);
            S_ACC:     phase_last = CW'(TAPS - 1);
            S_COLLECT: phase_last = CW'(ALU_LAT - 1);
            S_REDUCE:  phase_last = CW'(RED_LEN - 1);
            default:   phase_last = {CW{1'b0}};
        endcase
    endfunction

    // IDLE-only arbitration of the coefficient port; the host wins a tie.
    always_comb begin
        sample_ready = (state_r == S_IDLE) && !cload_req;
        cload_gnt    = (state_r == S_IDLE) && cload_req;
        accept_s     = sample_valid && (state_r == S_IDLE) && !cload_req;
        din_latch    = accept_s;
    end

    // Next phase, counter and head pointer.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        head_nx_s  = head_r;
        if (state_r == S_IDLE) begin
            if (accept_s) begin
                state_nx_s = S_LOAD;
                cnt_nx_s   = {CW{1'b0}};
            end else begin
                state_nx_s = S_IDLE;
            end
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_nx_s = cnt_r - CW'(1);
        end else begin
            state_nx_s = next_phase(state_r);
            cnt_nx_s   = phase_last(next_phase(state_r));
            if (state_r == S_LOAD) begin
                head_nx_s = head_r + AW'(1);
            end else begin
                head_nx_s = head_r;
            end
        end
    end

    // Output decode of the upcoming state, so the registered outputs line up with it.
    always_comb begin
        idx_s        = phase_last(state_nx_s) - cnt_nx_s;
        k_s          = idx_s + CW'(1);
        step_s       = idx_s / CW'(ALU_LAT);
        off_s        = idx_s % CW'(ALU_LAT);
        dmem_we_s    = 1'b0;
        dmem_addr_s  = {AW{1'b0}};
        cmem_addr_s  = {AW{1'b0}};
        regf_we_s    = 1'b0;
        regf_waddr_s = {AW{1'b0}};
        regf_raddr_s = {AW{1'b0}};
        alu_issue_s  = 1'b0;
        alu_op_s     = OP_NORM;
        alu_a_sel_s  = A_DIN;
        alu_b_sel_s  = B_CMEM;
        busy_s       = (state_nx_s != S_IDLE);
        out_valid_s  = 1'b0;
        case (state_nx_s)
            S_LOAD: begin
                dmem_we_s   = 1'b1;
                dmem_addr_s = head_nx_s;
                alu_issue_s = 1'b1;
                alu_op_s    = OP_MUL;
                alu_a_sel_s = A_DIN;
                alu_b_sel_s = B_CMEM;
            end
            S_MUL: begin
                // head already advanced on entry, so the newest sample sits at head-1
                dmem_addr_s = head_nx_s - AW'(1) - AW'(k_s);
                cmem_addr_s = AW'(k_s);
                alu_issue_s = 1'b1;
                alu_op_s    = OP_MUL;
                alu_a_sel_s = A_DMEM;
                alu_b_sel_s = B_CMEM;
                if (k_s >= CW'(ALU_LAT)) begin
                    regf_we_s    = 1'b1;
                    regf_waddr_s = AW'(k_s - CW'(ALU_LAT));
                end else begin
                    regf_we_s    = 1'b0;
                end
            end
            S_DRAIN: begin
                regf_we_s    = 1'b1;
                regf_waddr_s = AW'(CW'(TAPS - ALU_LAT) + idx_s);
            end
            S_ACC: begin
                regf_raddr_s = AW'(idx_s);
                alu_issue_s  = 1'b1;
                alu_op_s     = OP_ADD;
                alu_a_sel_s  = A_REGF;
                if (idx_s < CW'(ALU_LAT)) begin
                    alu_b_sel_s = B_ZERO;
                end else begin
                    alu_b_sel_s = B_SELF;
                end
            end
            S_COLLECT: begin
                regf_we_s    = 1'b1;
                regf_waddr_s = AW'(idx_s);
            end
            S_REDUCE: begin
                if (off_s == {CW{1'b0}}) begin
                    alu_issue_s  = 1'b1;
                    alu_a_sel_s  = A_REGF;
                    regf_raddr_s = AW'(step_s);
                    if (step_s == {CW{1'b0}}) begin
                        alu_b_sel_s = B_ZERO;
                    end else begin
                        alu_b_sel_s = B_SELF;
                    end
                    if (step_s == CW'(ALU_LAT - 1)) begin
                        alu_op_s = OP_NORM;
                    end else begin
                        alu_op_s = OP_ADD;
                    end
                end else begin
                    alu_issue_s = 1'b0;
                end
            end
            S_DONE: begin
                out_valid_s = 1'b1;
            end
            default: begin
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State, counter, head and registered outputs.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            cnt_r      <= {CW{1'b0}};
            head_r     <= {AW{1'b0}};
            dmem_we    <= 1'b0;
            dmem_addr  <= {AW{1'b0}};
            cmem_addr  <= {AW{1'b0}};
            regf_we    <= 1'b0;
            regf_waddr <= {AW{1'b0}};
            regf_raddr <= {AW{1'b0}};
            alu_issue  <= 1'b0;
            alu_op     <= 2'b00;
            alu_a_sel  <= 2'b00;
            alu_b_sel  <= 2'b00;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            head_r     <= head_nx_s;
            dmem_we    <= dmem_we_s;
            dmem_addr  <= dmem_addr_s;
            cmem_addr  <= cmem_addr_s;
            regf_we    <= regf_we_s;
            regf_waddr <= regf_waddr_s;
            regf_raddr <= regf_raddr_s;
            alu_issue  <= alu_issue_s;
            alu_op     <= alu_op_s;
            alu_a_sel  <= alu_a_sel_s;
            alu_b_sel  <= alu_b_sel_s;
            busy       <= busy_s;
            out_valid  <= out_valid_s;
        end
    end

endmodule
